// File: rtl/l2_responder.sv
`default_nettype none
// ============================================================================
// l2_responder : L2-side endpoint of the arbiter handshake; latches the
// granted core's request, runs one backing-memory access, returns the result.
// Optional watchdog abort when L2_TIMEOUT_EN is defined.
// Revision 1.0
// ============================================================================
module l2_responder #(
  parameter int N_CORES        = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GRANT_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GRANT_W-1:0]          grant,
  input  logic                        grant_ready,
  output logic                        busy,
  input  logic [N_CORES*ADDR_W-1:0]   req_addr,
  input  logic [N_CORES*DATA_W-1:0]   req_wdata,
  input  logic [N_CORES-1:0]          req_we,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [N_CORES-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [GRANT_W:0] GRANT_LIMIT = (GRANT_W+1)'(N_CORES);

  state_t              state_q, state_d;
  logic [GRANT_W-1:0]  owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q,    we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant_ok;

  assign grant_ok = ({1'b0, grant} < GRANT_LIMIT);

`ifdef L2_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef L2_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_ready && grant_ok) begin
          owner_d = grant;
          addr_d  = req_addr[grant*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[grant*DATA_W +: DATA_W];
          we_d    = req_we[grant];
          state_d = S_ISSUE;
`ifdef L2_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        // Ack beats the watchdog when both land in the same cycle
        if (mem_ack) begin
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = S_RESP;
        end
`ifdef L2_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
`ifdef L2_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
`ifdef L2_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // All outputs decode from registered state only
  assign busy       = (state_q != S_IDLE);
  assign mem_req    = (state_q == S_ISSUE);
  assign mem_we     = (state_q == S_ISSUE) && we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;

`ifdef L2_TIMEOUT_EN
  assign resp_err = (state_q == S_RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif

  for (genvar i = 0; i < N_CORES; i++) begin : g_resp
    localparam logic [GRANT_W-1:0] IDX = GRANT_W'(i);
    assign resp_valid[i] = (state_q == S_RESP) && (owner_q == IDX);
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_responder.sv
`default_nettype none
// ============================================================================
// tb_l2_responder : randomized self-checking bench for l2_responder.
// Revision 1.0
// ============================================================================
module tb_l2_responder;

  localparam int N_CORES = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TMO     = 8;
  localparam int GRANT_W = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [GRANT_W-1:0]        grant;
  logic                      grant_ready;
  logic                      busy;
  logic [N_CORES*ADDR_W-1:0] req_addr;
  logic [N_CORES*DATA_W-1:0] req_wdata;
  logic [N_CORES-1:0]        req_we;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ack;
  logic [DATA_W-1:0]         mem_rdata;
  logic [N_CORES-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  l2_responder #(
    .N_CORES(N_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .grant(grant), .grant_ready(grant_ready), .busy(busy),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_reqs();
    for (int c = 0; c < N_CORES; c++) begin
      req_addr[c*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
      req_wdata[c*DATA_W +: DATA_W] = $urandom;
    end
    req_we = N_CORES'($urandom);
  endtask

  // One full transaction; expected behaviour taken from the handshake timing:
  // mem_req from T+1 through T+1+k, response at T+2+k, idle at T+3+k.
  task automatic do_txn(input int core, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic we,
                        input int k, input logic [DATA_W-1:0] rd, input bit stray);
    logic [DATA_W-1:0] exp_rd;
    scramble_reqs();
    grant = GRANT_W'(core);
    req_addr[core*ADDR_W +: ADDR_W]  = a;
    req_wdata[core*DATA_W +: DATA_W] = wd;
    req_we[core] = we;
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    for (int j = 0; j <= k; j++) begin
      check_eq("busy_issue", 64'(busy), 64'd1);
      check_eq("mem_req", 64'(mem_req), 64'd1);
      check_eq("mem_addr", 64'(mem_addr), 64'(a));
      check_eq("mem_we", 64'(mem_we), 64'(we));
      if (we) check_eq("mem_wdata", 64'(mem_wdata), 64'(wd));
      check_eq("resp_idle", 64'(resp_valid), 64'd0);
      scramble_reqs();
      mem_rdata = (j == k) ? rd : $urandom;
      mem_ack   = (j == k);
      if (stray && j == 0 && k > 0) begin
        grant = 2'd3;
        grant_ready = 1'b1;
      end else begin
        grant_ready = 1'b0;
      end
      step();
    end
    mem_ack = 1'b0;
    grant_ready = 1'b0;
    exp_rd = we ? '0 : rd;
    check_eq("resp_valid", 64'(resp_valid), 64'(1) << core);
    check_eq("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
    check_eq("resp_err", 64'(resp_err), 64'd0);
    check_eq("busy_resp", 64'(busy), 64'd1);
    check_eq("mem_req_resp", 64'(mem_req), 64'd0);
    if (stray) begin
      grant = GRANT_W'($urandom);
      grant_ready = 1'b1;
    end
    mem_ack = stray;
    step();
    grant_ready = 1'b0;
    mem_ack = 1'b0;
    check_eq("busy_done", 64'(busy), 64'd0);
    check_eq("resp_done", 64'(resp_valid), 64'd0);
    check_eq("mem_req_done", 64'(mem_req), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; grant = '0; grant_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    req_addr = '0; req_wdata = '0; req_we = '0;
    step(); step();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);
    rst = 1'b0;

    // Idle with stray acks: nothing must happen
    for (int i = 0; i < 10; i++) begin
      mem_ack = 1'(i % 2);
      mem_rdata = $urandom;
      step();
      check_eq("idle_busy", 64'(busy), 64'd0);
      check_eq("idle_mem_req", 64'(mem_req), 64'd0);
      check_eq("idle_resp", 64'(resp_valid), 64'd0);
    end
    mem_ack = 1'b0;

    do_txn(2, 16'h1234, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b0);
    do_txn(0, 16'h0BAD, 32'hA5A5A5A5, 1'b1, 3, 32'h12345678, 1'b0);
    do_txn(1, 16'h4321, 32'h0, 1'b0, 2, 32'hCAFEF00D, 1'b1);
    do_txn(3, 16'h0003, 32'h0, 1'b0, 1, 32'h33333333, 1'b0);

    // Reset during S_ISSUE aborts without a response
    scramble_reqs();
    grant = 2'd1; grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    step();
    check_eq("pre_rst_mem_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_mem_req", 64'(mem_req), 64'd0);
    check_eq("abort_resp", 64'(resp_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      step();
      check_eq("post_abort_resp", 64'(resp_valid), 64'd0);
      check_eq("post_abort_busy", 64'(busy), 64'd0);
    end
    mem_ack = 1'b0;
    do_txn(2, 16'h7777, 32'h11112222, 1'b1, 1, 32'hFFFFFFFF, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_txn(int'($urandom_range(0, N_CORES-1)), ADDR_W'($urandom), $urandom,
             1'($urandom), int'($urandom_range(0, 5)), $urandom, 1'($urandom));
    end

`ifdef L2_TIMEOUT_EN
    begin
      int req_cycles = 0;
      bit seen = 1'b0;
      grant = 2'd3; grant_ready = 1'b1;
      step();
      grant_ready = 1'b0;
      for (int i = 0; i < TMO + 4 && !seen; i++) begin
        if (mem_req) begin
          req_cycles++;
        end else begin
          seen = 1'b1;
          check_eq("tmo_resp_valid", 64'(resp_valid), 64'b1000);
          check_eq("tmo_resp_err", 64'(resp_err), 64'd1);
          check_eq("tmo_resp_rdata", 64'(resp_rdata), 64'd0);
        end
        if (!seen) step();
      end
      check_eq("tmo_seen", 64'(seen), 64'd1);
      check_eq("tmo_req_cycles", 64'(req_cycles), 64'(TMO));
      step();
      check_eq("tmo_busy_done", 64'(busy), 64'd0);
      check_eq("tmo_resp_done", 64'(resp_valid), 64'd0);
      do_txn(0, 16'h0F0F, 32'h0, 1'b0, TMO - 1, 32'h55AA55AA, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
